// File: rtl/irrigacao_pkg.sv
// Shared definitions for the irrigation control path:
// state encoding and width used by the FSM and its consumers.
package irrigacao_pkg;

    localparam int unsigned ESTADO_W = 2;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO    = 2'd0,
        IRRIGANDO = 2'd1,
        DESCANSO  = 2'd2,
        ALARME    = 2'd3
    } estado_t;

endpackage

// File: rtl/controle_irrigacao_sincronizador.sv
// Two-flop synchronizer for asynchronous sensor levels.
// Resets to 0 so a sensor reads inactive until sampled twice.
module sincronizador (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sinc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sinc_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sinc_q <= meta_q;
        end
    end

    assign q_o = sinc_q;

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation controller: timed watering, mandatory rest,
// manual stop and latched tank-empty alarm driving the pump.
module controle_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned DURACAO  = 10,
    parameter int unsigned PAUSA    = 5,
    parameter int unsigned CONT_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                botao_pulso,
    input  logic                umidade_baixa,
    input  logic                tanque_vazio,
    output logic                bomba,
    output logic                alarme,
    output logic [ESTADO_W-1:0] estado,
    output logic [CONT_W-1:0]   tempo_restante
);

    localparam int unsigned PW =
        (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CONT_W-1:0] T_IRR     = CONT_W'(DURACAO);
    localparam logic [CONT_W-1:0] T_DESC    = CONT_W'(PAUSA);
    localparam logic [CONT_W-1:0] UM        = CONT_W'(1);

    logic tanque_s;
    logic seco_s;

    sincronizador u_sinc_tanque (
        .clock (clock),
        .reset (reset),
        .d_i   (tanque_vazio),
        .q_o   (tanque_s)
    );

    sincronizador u_sinc_umidade (
        .clock (clock),
        .reset (reset),
        .d_i   (umidade_baixa),
        .q_o   (seco_s)
    );

    estado_t           estado_q, estado_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CONT_W-1:0] tempo_q, tempo_d;
    logic              bomba_q, bomba_d;
    logic              alarme_q, alarme_d;
    logic              temporizado;
    logic              tick;
    logic              fim;

    assign temporizado = (estado_q == IRRIGANDO) ||
                         (estado_q == DESCANSO);
    assign tick = temporizado && (presc_q == PRESC_MAX);
    assign fim  = tick && (tempo_q == UM);

    always_comb begin
        estado_d = estado_q;
        tempo_d  = tempo_q;
        presc_d  = presc_q;
        if (temporizado) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        unique case (estado_q)
            OCIOSO: begin
                if (tanque_s) begin
                    estado_d = ALARME;
                end else if (botao_pulso || seco_s) begin
                    estado_d = IRRIGANDO;
                    tempo_d  = T_IRR;
                    presc_d  = '0;
                end
            end
            IRRIGANDO: begin
                if (tanque_s) begin
                    estado_d = ALARME;
                    tempo_d  = '0;
                end else if (botao_pulso || fim) begin
                    estado_d = DESCANSO;
                    tempo_d  = T_DESC;
                    presc_d  = '0;
                end else if (tick) begin
                    tempo_d = tempo_q - UM;
                end
            end
            DESCANSO: begin
                if (tanque_s) begin
                    estado_d = ALARME;
                    tempo_d  = '0;
                end else if (fim) begin
                    estado_d = OCIOSO;
                    tempo_d  = '0;
                end else if (tick) begin
                    tempo_d = tempo_q - UM;
                end
            end
            ALARME: begin
                tempo_d = '0;
                // Only a press with the tank refilled clears the alarm
                if (botao_pulso && !tanque_s) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
                tempo_d  = '0;
            end
        endcase
        bomba_d  = (estado_d == IRRIGANDO);
        alarme_d = (estado_d == ALARME);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            presc_q  <= '0;
            tempo_q  <= '0;
            bomba_q  <= 1'b0;
            alarme_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            presc_q  <= presc_d;
            tempo_q  <= tempo_d;
            bomba_q  <= bomba_d;
            alarme_q <= alarme_d;
        end
    end

    assign estado         = estado_q;
    assign bomba          = bomba_q;
    assign alarme         = alarme_q;
    assign tempo_restante = tempo_q;

endmodule
